// File: rtl/ysyx_210184_regfile_if.sv
// Writeback, decode read and issue/scoreboard signals shared by the regfile and its pipeline neighbours.
interface ysyx_210184_regfile_if #(
    parameter int REG_BUS = 64
);
    logic               w_ena;
    logic [4:0]         w_addr;
    logic [REG_BUS-1:0] w_data;
    logic               r1_ena;
    logic [4:0]         r1_addr;
    logic [REG_BUS-1:0] r1_data;
    logic               r2_ena;
    logic [4:0]         r2_addr;
    logic [REG_BUS-1:0] r2_data;
    logic               issue_valid;
    logic               issue_w_ena;
    logic [4:0]         issue_rd;
    logic               flush;
    logic               stall_o;

    modport master (
        output w_ena, w_addr, w_data,
        output r1_ena, r1_addr, r2_ena, r2_addr,
        output issue_valid, issue_w_ena, issue_rd, flush,
        input  r1_data, r2_data, stall_o
    );

    modport slave (
        input  w_ena, w_addr, w_data,
        input  r1_ena, r1_addr, r2_ena, r2_addr,
        input  issue_valid, issue_w_ena, issue_rd, flush,
        output r1_data, r2_data, stall_o
    );
endinterface

// File: rtl/ysyx_210184_regfile.sv
// Integer regfile with in-flight write scoreboard; reads are 0-cycle with write-first bypass.
// Backpressure: stall_o combinationally refuses an issue while a source is pending or the rd counter is saturated.
module ysyx_210184_regfile #(
    parameter int REG_BUS = 64,
    parameter int NREG    = 32,
    parameter int CNT_W   = 2
) (
    input logic                  clk,
    input logic                  rst,
    ysyx_210184_regfile_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [REG_BUS-1:0] regs [1:NREG-1];
    logic [CNT_W-1:0]   cnt  [1:NREG-1];

    logic [CNT_W-1:0] cnt_r1, cnt_r2, cnt_rd, cnt_w;
    logic             pend1, pend2, rd_full;
    logic             inc, dec, w_hit;

    always_comb begin
        cnt_r1       = '0;
        cnt_r2       = '0;
        cnt_rd       = '0;
        cnt_w        = '0;
        bus.r1_data  = '0;
        bus.r2_data  = '0;
        // x0 has no counter: every lookup for address 0 reads as idle
        if (bus.r1_addr != 5'd0)  cnt_r1 = cnt[bus.r1_addr];
        if (bus.r2_addr != 5'd0)  cnt_r2 = cnt[bus.r2_addr];
        if (bus.issue_rd != 5'd0) cnt_rd = cnt[bus.issue_rd];
        if (bus.w_addr != 5'd0)   cnt_w  = cnt[bus.w_addr];

        if (bus.r1_ena && bus.r1_addr != 5'd0)
            bus.r1_data = (bus.w_ena && bus.w_addr == bus.r1_addr) ? bus.w_data : regs[bus.r1_addr];
        if (bus.r2_ena && bus.r2_addr != 5'd0)
            bus.r2_data = (bus.w_ena && bus.w_addr == bus.r2_addr) ? bus.w_data : regs[bus.r2_addr];

        // A source whose last in-flight write retires this cycle is served by the bypass instead
        pend1 = bus.r1_ena && cnt_r1 != '0 &&
                !(bus.w_ena && bus.w_addr == bus.r1_addr && cnt_r1 == CNT_ONE);
        pend2 = bus.r2_ena && cnt_r2 != '0 &&
                !(bus.w_ena && bus.w_addr == bus.r2_addr && cnt_r2 == CNT_ONE);
        rd_full = bus.issue_w_ena && bus.issue_rd != 5'd0 && cnt_rd == CNT_MAX;

        bus.stall_o = bus.issue_valid && (pend1 || pend2 || rd_full);
        w_hit       = bus.w_ena && bus.w_addr != 5'd0;
        inc = bus.issue_valid && bus.issue_w_ena && bus.issue_rd != 5'd0 &&
              !bus.stall_o && !bus.flush;
        dec = w_hit && cnt_w != '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) regs[i] <= '0;
        end else if (w_hit) begin
            regs[bus.w_addr] <= bus.w_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) cnt[i] <= '0;
        end else if (bus.flush) begin
            for (int i = 1; i < NREG; i++) cnt[i] <= '0;
        end else begin
            // Issue and retire to the same register cancel out
            for (int i = 1; i < NREG; i++) begin
                if (inc && bus.issue_rd == 5'(i) && !(dec && bus.w_addr == 5'(i)))
                    cnt[i] <= cnt[i] + CNT_ONE;
                else if (dec && bus.w_addr == 5'(i) && !(inc && bus.issue_rd == 5'(i)))
                    cnt[i] <= cnt[i] - CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_210184_regfile.sv
// Directed and randomized bench for the regfile against an array/integer model of its rules.
module tb_ysyx_210184_regfile;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_210184_regfile_if #(.REG_BUS(64)) bus ();
    ysyx_210184_regfile #(.REG_BUS(64), .NREG(32), .CNT_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    logic [63:0] ref_regs [32];
    int          ref_cnt  [32];

    task automatic idle();
        bus.w_ena = 0; bus.w_addr = 0; bus.w_data = 0;
        bus.r1_ena = 0; bus.r1_addr = 0; bus.r2_ena = 0; bus.r2_addr = 0;
        bus.issue_valid = 0; bus.issue_w_ena = 0; bus.issue_rd = 0; bus.flush = 0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            ref_regs[i] = 0;
            ref_cnt[i]  = 0;
        end
    endtask

    function automatic logic [63:0] m_read(input logic ena, input logic [4:0] a);
        if (!ena || a == 0) return 64'd0;
        if (bus.w_ena && bus.w_addr == a) return bus.w_data;
        return ref_regs[a];
    endfunction

    function automatic logic m_pend(input logic ena, input logic [4:0] a);
        if (!ena || a == 0 || ref_cnt[a] == 0) return 1'b0;
        return !(bus.w_ena && bus.w_addr == a && ref_cnt[a] == 1);
    endfunction

    function automatic logic m_stall();
        logic full;
        full = bus.issue_w_ena && bus.issue_rd != 0 && ref_cnt[bus.issue_rd] == 3;
        return bus.issue_valid && (m_pend(bus.r1_ena, bus.r1_addr) ||
                                   m_pend(bus.r2_ena, bus.r2_addr) || full);
    endfunction

    // Advance one clock edge, applying the same edge to the model
    task automatic tick();
        logic st;
        st = m_stall();
        if (bus.flush) begin
            for (int i = 0; i < 32; i++) ref_cnt[i] = 0;
        end else begin
            if (bus.w_ena && bus.w_addr != 0 && ref_cnt[bus.w_addr] > 0) ref_cnt[bus.w_addr]--;
            if (bus.issue_valid && bus.issue_w_ena && bus.issue_rd != 0 && !st) ref_cnt[bus.issue_rd]++;
        end
        if (bus.w_ena && bus.w_addr != 0) ref_regs[bus.w_addr] = bus.w_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        bus.r1_ena = 1; bus.r1_addr = 5;
        bus.issue_valid = 1; bus.issue_w_ena = 1; bus.issue_rd = 5;
        #1;
        checks++;
        if (bus.r1_data !== 64'd0) begin errors++; $display("FAIL reset_read: got %h expected 0", bus.r1_data); end
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o); end
        bus.w_ena = 1; bus.w_addr = 6; bus.w_data = 64'h5A5A; bus.r2_ena = 1; bus.r2_addr = 6;
        #1;
        checks++;
        if (bus.r2_data !== 64'h5A5A) begin errors++; $display("FAIL reset_bypass: got %h expected 5a5a", bus.r2_data); end
        idle();
        @(negedge clk); #2;
        rst = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            bus.r1_ena = 1; bus.r1_addr = 5'(i);
            #1;
            checks++;
            if (bus.r1_data !== 64'd0) begin errors++; $display("FAIL post_reset_x%0d: got %h expected 0", i, bus.r1_data); end
        end
        idle();
    endtask

    task automatic test_write_read();
        bus.w_ena = 1; bus.w_addr = 5; bus.w_data = 64'h1122334455667788;
        tick(); idle();
        bus.r1_ena = 1; bus.r1_addr = 5;
        #2;
        checks++;
        if (bus.r1_data !== 64'h1122334455667788) begin errors++; $display("FAIL read_x5: got %h expected 1122334455667788", bus.r1_data); end
        bus.r1_ena = 0;
        #1;
        checks++;
        if (bus.r1_data !== 64'd0) begin errors++; $display("FAIL read_disabled: got %h expected 0", bus.r1_data); end
        idle();
        bus.w_ena = 1; bus.w_addr = 0; bus.w_data = 64'hFF;
        tick(); idle();
        bus.r2_ena = 1; bus.r2_addr = 0;
        #2;
        checks++;
        if (bus.r2_data !== 64'd0) begin errors++; $display("FAIL read_x0: got %h expected 0", bus.r2_data); end
        idle();
    endtask

    task automatic test_bypass();
        bus.w_ena = 1; bus.w_addr = 7; bus.w_data = 64'hABCD;
        bus.r2_ena = 1; bus.r2_addr = 7;
        #2;
        checks++;
        if (bus.r2_data !== 64'hABCD) begin errors++; $display("FAIL bypass_same_cycle: got %h expected abcd", bus.r2_data); end
        tick(); idle();
        bus.r2_ena = 1; bus.r2_addr = 7;
        #2;
        checks++;
        if (bus.r2_data !== 64'hABCD) begin errors++; $display("FAIL bypass_stored: got %h expected abcd", bus.r2_data); end
        idle();
    endtask

    task automatic test_load_use();
        bus.issue_valid = 1; bus.issue_w_ena = 1; bus.issue_rd = 3;
        #2;
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL load_issue: got %b expected 0", bus.stall_o); end
        tick(); idle();
        bus.issue_valid = 1; bus.r1_ena = 1; bus.r1_addr = 3;
        #2;
        checks++;
        if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b expected 1", bus.stall_o); end
        bus.w_ena = 1; bus.w_addr = 3; bus.w_data = 64'hDEADBEEF00000033;
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b expected 0", bus.stall_o); end
        checks++;
        if (bus.r1_data !== 64'hDEADBEEF00000033) begin errors++; $display("FAIL load_use_data: got %h expected deadbeef00000033", bus.r1_data); end
        tick(); idle();
    endtask

    task automatic test_multi_inflight();
        for (int k = 0; k < 3; k++) begin
            bus.issue_valid = 1; bus.issue_w_ena = 1; bus.issue_rd = 4;
            #2;
            checks++;
            if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL multi_issue_%0d: got %b expected 0", k, bus.stall_o); end
            tick(); idle();
        end
        bus.issue_valid = 1; bus.issue_w_ena = 1; bus.issue_rd = 4;
        #2;
        checks++;
        if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL multi_full: got %b expected 1", bus.stall_o); end
        bus.w_ena = 1; bus.w_addr = 4; bus.w_data = 64'h44;
        #1;
        checks++;
        if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL multi_full_wb: got %b expected 1", bus.stall_o); end
        tick();
        bus.w_ena = 0;
        #2;
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL multi_accept: got %b expected 0", bus.stall_o); end
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            bus.w_ena = 1; bus.w_addr = 4; bus.w_data = 64'h4400 + 64'(k);
            tick();
        end
        idle();
        bus.issue_valid = 1; bus.r1_ena = 1; bus.r1_addr = 4;
        #2;
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL multi_drained: got %b expected 0", bus.stall_o); end
        checks++;
        if (bus.r1_data !== 64'h4402) begin errors++; $display("FAIL multi_data: got %h expected 4402", bus.r1_data); end
        idle();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 2; k++) begin
            bus.issue_valid = 1; bus.issue_w_ena = 1; bus.issue_rd = 9;
            tick();
        end
        bus.flush = 1;
        tick(); idle();
        bus.issue_valid = 1; bus.r1_ena = 1; bus.r1_addr = 9;
        #2;
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL flush_clear: got %b expected 0", bus.stall_o); end
        idle();
        bus.w_ena = 1; bus.w_addr = 9; bus.w_data = 64'h9999;
        tick(); idle();
        bus.issue_valid = 1; bus.r1_ena = 1; bus.r1_addr = 9;
        #2;
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL flush_no_underflow: got %b expected 0", bus.stall_o); end
        checks++;
        if (bus.r1_data !== 64'h9999) begin errors++; $display("FAIL flush_wb_data: got %h expected 9999", bus.r1_data); end
        idle();
    endtask

    task automatic test_random();
        logic [63:0] e1, e2;
        logic        es;
        for (int n = 0; n < 500; n++) begin
            bus.w_ena       = 1'($urandom_range(0, 1));
            bus.w_addr      = 5'($urandom_range(0, 6));
            bus.w_data      = {$urandom, $urandom};
            bus.r1_ena      = 1'($urandom_range(0, 3) != 0);
            bus.r1_addr     = 5'($urandom_range(0, 6));
            bus.r2_ena      = 1'($urandom_range(0, 3) != 0);
            bus.r2_addr     = 5'($urandom_range(0, 6));
            bus.issue_valid = 1'($urandom_range(0, 3) != 0);
            bus.issue_w_ena = 1'($urandom_range(0, 3) != 0);
            bus.issue_rd    = 5'($urandom_range(0, 6));
            bus.flush       = 1'($urandom_range(0, 29) == 0);
            #2;
            e1 = m_read(bus.r1_ena, bus.r1_addr);
            e2 = m_read(bus.r2_ena, bus.r2_addr);
            es = m_stall();
            checks++;
            if (bus.r1_data !== e1) begin errors++; $display("FAIL rand_r1 n=%0d: got %h expected %h", n, bus.r1_data, e1); end
            checks++;
            if (bus.r2_data !== e2) begin errors++; $display("FAIL rand_r2 n=%0d: got %h expected %h", n, bus.r2_data, e2); end
            checks++;
            if (bus.stall_o !== es) begin errors++; $display("FAIL rand_stall n=%0d: got %b expected %b", n, bus.stall_o, es); end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        bus.flush = 1;
        tick(); idle();
        bus.w_ena = 1; bus.w_addr = 10; bus.w_data = 64'hA0A0;
        bus.issue_valid = 1; bus.issue_w_ena = 1; bus.issue_rd = 11;
        tick(); idle();
        bus.issue_valid = 1; bus.issue_w_ena = 1; bus.issue_rd = 12;
        tick(); idle();
        bus.issue_valid = 1; bus.r1_ena = 1; bus.r1_addr = 11; bus.r2_ena = 1; bus.r2_addr = 12;
        #2;
        checks++;
        if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b expected 1", bus.stall_o); end
        #1;
        rst = 0;
        m_reset();
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL async_reset_stall: got %b expected 0", bus.stall_o); end
        bus.r1_addr = 10;
        #1;
        checks++;
        if (bus.r1_data !== 64'd0) begin errors++; $display("FAIL async_reset_x10: got %h expected 0", bus.r1_data); end
        idle();
        @(negedge clk); #2;
        rst = 1;
        @(posedge clk); #1;
        bus.issue_valid = 1; bus.issue_w_ena = 1; bus.issue_rd = 11;
        bus.r1_ena = 1; bus.r1_addr = 11; bus.r2_ena = 1; bus.r2_addr = 12;
        #2;
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %b expected 0", bus.stall_o); end
        tick(); idle();
        bus.issue_valid = 1; bus.r1_ena = 1; bus.r1_addr = 11;
        #2;
        checks++;
        if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL post_reset_busy: got %b expected 1", bus.stall_o); end
        idle();
    endtask

    initial begin
        rst = 0;
        idle();
        m_reset();
        test_reset();
        test_write_read();
        test_bypass();
        test_load_use();
        test_multi_inflight();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_210184_regfile.md
# ysyx_210184_regfile

Integer register file and write-pending scoreboard for the ysyx_210184 five-stage core. It sinks the writeback stage's `wb_data_o`/`rd_o`/`w_ena_o` triple on its write port and serves decode on two combinational read ports with write-first bypass. A per-register in-flight counter tracks destinations issued by decode but not yet written back, and raises a stall when a source operand is still pending.

## Interface
- `REG_BUS`, 64: register width (from `defines.v`).
- `NREG`, 32: number of architectural registers; x0 is hardwired to zero.
- `CNT_W`, 2: width of each in-flight counter; the maximum count is 2^CNT_W-1 = 3.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `w_ena`  in  1  write enable from writeback.
- `w_addr`  in  5  destination register from writeback.
- `w_data`  in  REG_BUS  write data from writeback.
- `r1_ena`, `r2_ena`  in  1  source-operand read enables from decode.
- `r1_addr`, `r2_addr`  in  5  source register indices.
- `r1_data`, `r2_data`  out  REG_BUS  read data; 0 when the enable is low or the address is 0.
- `issue_valid`  in  1  decode presents an instruction this cycle.
- `issue_w_ena`  in  1  the instruction writes a destination register.
- `issue_rd`  in  5  destination register of the issuing instruction.
- `flush`  in  1  pipeline flush; clears every in-flight counter.
- `stall_o`  out  1  decode must hold; the issue is not accepted.

## Operation
- Storage: `NREG-1` registers of `REG_BUS` bits for x1..x31. Reading x0 always returns 0. A write to x0 is discarded.
- Write: on a clock edge with `w_ena=1` and `w_addr!=0`, `reg[w_addr] <= w_data`.
- Read (combinational): `rN_data` is selected in this priority order:
  - 0 if `!rN_ena` or `rN_addr==0`;
  - `w_data` if `w_ena` and `w_addr==rN_addr` (write-first bypass);
  - otherwise `reg[rN_addr]`.
- Scoreboard: each register x1..x31 has a `CNT_W`-bit counter `cnt[i]`; x0 has no counter and is never busy.
  - `inc = issue_valid & issue_w_ena & (issue_rd!=0) & !stall_o & !flush`.
  - `dec = w_ena & (w_addr!=0) & cnt[w_addr]!=0`.
  - If `inc` and `dec` target the same register, its counter is unchanged. Otherwise `inc` adds 1 to `cnt[issue_rd]` and `dec` subtracts 1 from `cnt[w_addr]`.
  - A writeback to a register whose counter is 0 (for example, after a flush) still writes the data; the counter stays at 0 and never underflows.
- Busy test for a source register N: `busyN = rN_ena & rN_addr!=0 & cnt[rN_addr]!=0`. A source is still considered pending unless that same cycle's writeback retires its last in-flight write: `pendN = busyN & !(w_ena & w_addr==rN_addr & cnt[rN_addr]==1)`.
- Stall: `stall_o = issue_valid & (pend1 | pend2 | (issue_w_ena & issue_rd!=0 & cnt[issue_rd]==3))`. The last term prevents counter overflow.
- Flush: on a clock edge with `flush=1`, every counter is cleared to 0. Flush overrides any simultaneous `inc`/`dec`. A simultaneous register write still takes effect.

## Timing
- Reset (rst=0, asynchronous): all registers and all counters cleared to 0. While reset is asserted, reads return 0 except where the bypass applies, and `stall_o` depends only on the inputs (every counter is 0).
- Read latency is 0 cycles; data written at edge k is visible from storage after edge k, and is visible through the bypass during cycle k itself.
- Scoreboard latency: an issue accepted at edge k makes `issue_rd` busy for reads in cycle k+1 onward.
- `stall_o` is purely combinational from the current inputs and counter state. There is no registered handshake: decode re-presents the same instruction until `stall_o=0`.
- Reset deasserted in the middle of a cycle: state becomes valid and updates at the first subsequent rising edge.

## Test plan
- Reset, then write x5=0x1122334455667788 and read x5 on r1 in the following cycle -> `r1_data=0x1122334455667788`. Write x0=0xFF -> a read of x0 returns 0.
- Bypass: in the same cycle, `w_ena=1, w_addr=7, w_data=0xABCD` and `r2_addr=7` while `reg[7]=0` -> `r2_data=0xABCD`. On the next cycle the stored value is also 0xABCD.
- Load-use stall: issue with rd=3; the next cycle reads r1_addr=3 -> `stall_o=1`. When the writeback of x3 arrives in the same cycle as that read -> `stall_o=0` and `r1_data` equals the bypassed value.
- Multiple in-flight writes: issue rd=4 three times, then attempt a 4th issue to rd=4 -> `stall_o=1`. After one writeback to x4 -> `cnt[4]=2` and the 4th issue is accepted.
- Flush: with cnt[9]=2, assert `flush` together with an issue to rd=9 -> `cnt[9]=0` and a read of x9 does not stall. A later writeback to x9 writes the data and leaves `cnt[9]=0`.
- Asynchronous reset mid-operation: with counters nonzero, pull rst low between edges -> all counters and registers read 0 immediately, and `stall_o=0` for any read.
